// File: rtl/lookup_stage.sv
// rtl/lookup_stage.sv - one level of a pipelined binary-tree lookup with a verified table-update port
module lookup_stage #(
   parameter int STAGE_ID = 0,
   parameter int DATA     = 72,
   parameter int ADDR     = 10,
   parameter int KEY      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [KEY-1:0]  in_key,
   input  logic [ADDR-1:0] in_addr,
   input  logic [15:0]     in_res,
   input  logic            in_hit,
   output logic            out_valid,
   output logic [KEY-1:0]  out_key,
   output logic [ADDR-1:0] out_addr,
   output logic [15:0]     out_res,
   output logic            out_hit,
   output logic [ADDR-1:0] ram_a_addr,
   input  logic [DATA-1:0] ram_a_dout,
   input  logic            upd_valid,
   input  logic [ADDR-1:0] upd_addr,
   input  logic [DATA-1:0] upd_data,
   output logic            upd_ready,
   output logic            upd_done,
   output logic            upd_err,
   output logic            ram_b_wr,
   output logic [ADDR-1:0] ram_b_addr,
   output logic [DATA-1:0] ram_b_din,
   input  logic [DATA-1:0] ram_b_dout
);

   // Node word fields, packed from the MSB down: pivot, left, right, result, result_valid, reserved.
   localparam int PIV_LSB = DATA - KEY;
   localparam int L_LSB   = PIV_LSB - ADDR;
   localparam int R_LSB   = L_LSB - ADDR;
   localparam int RES_LSB = R_LSB - 16;
   localparam int RV_BIT  = RES_LSB - 1;

   localparam logic [ADDR-1:0] NULL_PTR = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CHECK} upd_state_t;

   logic            p1_valid_q, p1_valid_d;
   logic [KEY-1:0]  p1_key_q, p1_key_d;
   logic [ADDR-1:0] p1_addr_q, p1_addr_d;
   logic [15:0]     p1_res_q, p1_res_d;
   logic            p1_hit_q, p1_hit_d;

   logic            out_valid_q, out_valid_d;
   logic [KEY-1:0]  out_key_q, out_key_d;
   logic [ADDR-1:0] out_addr_q, out_addr_d;
   logic [15:0]     out_res_q, out_res_d;
   logic            out_hit_q, out_hit_d;

   upd_state_t      state_q, state_d;
   logic [ADDR-1:0] cap_addr_q, cap_addr_d;
   logic [DATA-1:0] cap_data_q, cap_data_d;
   logic            upd_err_q, upd_err_d;

   logic [KEY-1:0]  node_pivot;
   logic [ADDR-1:0] node_left, node_right;
   logic [15:0]     node_res;
   logic            node_rv;
   logic            go_right;
   logic            mismatch;
   logic            unused_rsvd;

   // The RAM lookup port sees the incoming pointer directly so its read latency lines up with P1.
   assign ram_a_addr = in_addr;

   assign node_pivot  = ram_a_dout[DATA-1:PIV_LSB];
   assign node_left   = ram_a_dout[L_LSB +: ADDR];
   assign node_right  = ram_a_dout[R_LSB +: ADDR];
   assign node_res    = ram_a_dout[RES_LSB +: 16];
   assign node_rv     = ram_a_dout[RV_BIT];
   assign unused_rsvd = ^ram_a_dout[RV_BIT-1:0];
   assign go_right    = (p1_key_q >= node_pivot);

   // P1 next state: capture the token unconditionally, there is no back-pressure.
   always_comb begin
      p1_valid_d = in_valid;
      p1_key_d   = in_key;
      p1_addr_d  = in_addr;
      p1_res_d   = in_res;
      p1_hit_d   = in_hit;
   end

   // P2 next state: descend the tree, a NULL pointer passes the token through untouched.
   always_comb begin
      out_valid_d = p1_valid_q;
      out_key_d   = p1_key_q;
      out_addr_d  = NULL_PTR;
      out_res_d   = p1_res_q;
      out_hit_d   = p1_hit_q;
      if (p1_addr_q != NULL_PTR) begin
         out_addr_d = go_right ? node_right : node_left;
         if (go_right && node_rv) begin
            out_res_d = node_res;
            out_hit_d = 1'b1;
         end
      end
   end

   // Lookup pipeline registers; reset drops any token in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_valid_q  <= 1'b0;
         p1_key_q    <= '0;
         p1_addr_q   <= NULL_PTR;
         p1_res_q    <= '0;
         p1_hit_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_key_q   <= '0;
         out_addr_q  <= NULL_PTR;
         out_res_q   <= '0;
         out_hit_q   <= 1'b0;
      end else begin
         p1_valid_q  <= p1_valid_d;
         p1_key_q    <= p1_key_d;
         p1_addr_q   <= p1_addr_d;
         p1_res_q    <= p1_res_d;
         p1_hit_q    <= p1_hit_d;
         out_valid_q <= out_valid_d;
         out_key_q   <= out_key_d;
         out_addr_q  <= out_addr_d;
         out_res_q   <= out_res_d;
         out_hit_q   <= out_hit_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_key   = out_key_q;
   assign out_addr  = out_addr_q;
   assign out_res   = out_res_q;
   assign out_hit   = out_hit_q;

   // Read-back data arrives in CHECK, one cycle after READ presented the address.
   assign mismatch = (ram_b_dout != cap_data_q);

   // Update FSM next state: write once, read back, compare, then accept the next request.
   always_comb begin
      state_d    = state_q;
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      upd_err_d  = upd_err_q;
      case (state_q)
         ST_IDLE: begin
            if (upd_valid) begin
               cap_addr_d = upd_addr;
               cap_data_d = upd_data;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_READ;
         ST_READ:  state_d = ST_CHECK;
         ST_CHECK: begin
            upd_err_d = mismatch;
            state_d   = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Update FSM registers; reset abandons a write in progress without reporting it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cap_addr_q <= '0;
         cap_data_q <= '0;
         upd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cap_addr_q <= cap_addr_d;
         cap_data_q <= cap_data_d;
         upd_err_q  <= upd_err_d;
      end
   end

   // Strobes decode straight from the state so reset removes them in the same instant.
   assign upd_ready  = (state_q == ST_IDLE);
   assign ram_b_wr   = (state_q == ST_WRITE);
   assign upd_done   = (state_q == ST_CHECK);
   assign upd_err    = upd_done ? mismatch : upd_err_q;
   assign ram_b_addr = cap_addr_q;
   assign ram_b_din  = cap_data_q;

   // The FSM never reports completion while it is still driving a write.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(ram_b_wr && upd_done))
            else $error("lookup_stage %0d: write and done overlap", STAGE_ID);
      end
   end

endmodule

// File: tb/tb_lookup_stage.sv
// tb/tb_lookup_stage.sv - directed bench for lookup_stage
module tb_lookup_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_key;
   logic [9:0]  in_addr;
   logic [15:0] in_res;
   logic        in_hit;
   logic        out_valid;
   logic [31:0] out_key;
   logic [9:0]  out_addr;
   logic [15:0] out_res;
   logic        out_hit;
   logic [9:0]  ram_a_addr;
   logic [71:0] ram_a_dout;
   logic        upd_valid;
   logic [9:0]  upd_addr;
   logic [71:0] upd_data;
   logic        upd_ready;
   logic        upd_done;
   logic        upd_err;
   logic        ram_b_wr;
   logic [9:0]  ram_b_addr;
   logic [71:0] ram_b_din;
   logic [71:0] ram_b_dout;

   logic [71:0] mem [0:1023];
   logic        corrupt;
   logic        tb_we;
   logic [9:0]  tb_wa;
   logic [71:0] tb_wd;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   lookup_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_key     (in_key),
      .in_addr    (in_addr),
      .in_res     (in_res),
      .in_hit     (in_hit),
      .out_valid  (out_valid),
      .out_key    (out_key),
      .out_addr   (out_addr),
      .out_res    (out_res),
      .out_hit    (out_hit),
      .ram_a_addr (ram_a_addr),
      .ram_a_dout (ram_a_dout),
      .upd_valid  (upd_valid),
      .upd_addr   (upd_addr),
      .upd_data   (upd_data),
      .upd_ready  (upd_ready),
      .upd_done   (upd_done),
      .upd_err    (upd_err),
      .ram_b_wr   (ram_b_wr),
      .ram_b_addr (ram_b_addr),
      .ram_b_din  (ram_b_din),
      .ram_b_dout (ram_b_dout)
   );

   // Dual-port read-first RAM; corrupt flips bit 0 on the update-port read-back.
   always @(posedge clk) begin
      ram_a_dout <= mem[ram_a_addr];
      ram_b_dout <= mem[ram_b_addr] ^ {71'd0, corrupt};
      if (ram_b_wr) mem[ram_b_addr] <= ram_b_din;
      if (tb_we)    mem[tb_wa]      <= tb_wd;
   end

   function automatic logic [71:0] node(input logic [31:0] piv, input logic [9:0] l,
                                        input logic [9:0] r, input logic [15:0] res,
                                        input logic rv);
      return {piv, l, r, res, rv, 3'b000};
   endfunction

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [71:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic drive_tok(input logic [31:0] k, input logic [9:0] a,
                            input logic [15:0] r, input logic h);
      in_valid = 1'b1; in_key = k; in_addr = a; in_res = r; in_hit = h;
   endtask

   task automatic do_update(input logic [9:0] a, input logic [71:0] d, input logic exp_err,
                            input logic [9:0] exp_look_addr);
      @(negedge clk);
      check("upd_ready_idle", upd_ready, 1);
      upd_valid = 1'b1; upd_addr = a; upd_data = d;
      @(negedge clk);
      upd_valid = 1'b0;
      check("wr_high", ram_b_wr, 1);
      check("wr_addr", ram_b_addr, a);
      check("wr_din", ram_b_din, d);
      check("ready_busy", upd_ready, 0);
      drive_tok(32'h1, a, 16'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("wr_one_cycle", ram_b_wr, 0);
      check("read_addr_held", ram_b_addr, a);
      check("done_early", upd_done, 0);
      @(negedge clk);
      check("done_pulse", upd_done, 1);
      check("err_at_done", upd_err, exp_err);
      check("readfirst_valid", out_valid, 1);
      check("readfirst_addr", out_addr, exp_look_addr);
      @(negedge clk);
      check("done_cleared", upd_done, 0);
      check("ready_again", upd_ready, 1);
      check("err_held", upd_err, exp_err);
   endtask

   logic [31:0] t_key  [8] = '{32'h0A000000, 32'h09FFFFFF, 32'h80000000, 32'h7FFFFFFF,
                               32'hFFFFFFFF, 32'h000000FF, 32'h12345678, 32'hFFFFFFFF};
   logic [9:0]  t_addr [8] = '{10'd5, 10'd5, 10'd6, 10'd6, 10'd7, 10'd7, 10'h3FF, 10'd5};
   logic [15:0] t_res  [8] = '{16'h0000, 16'h0011, 16'h0077, 16'h0001,
                               16'h0000, 16'h0099, 16'h0055, 16'h00AA};
   logic        t_hit  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [9:0]  e_addr [8] = '{10'd7, 10'd3, 10'h020, 10'h010, 10'd2, 10'd1, 10'h3FF, 10'd7};
   logic [15:0] e_res  [8] = '{16'h0042, 16'h0011, 16'h0077, 16'h0001,
                               16'hBEEF, 16'h0099, 16'h0055, 16'h0042};
   logic        e_hit  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0; corrupt = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
      in_valid = 1'b0; in_key = '0; in_addr = 10'h2A5; in_res = '0; in_hit = 1'b0;
      upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_key", out_key, 0);
      check("rst_out_addr", out_addr, 10'h3FF);
      check("rst_out_res", out_res, 0);
      check("rst_out_hit", out_hit, 0);
      check("rst_upd_ready", upd_ready, 1);
      check("rst_upd_done", upd_done, 0);
      check("rst_upd_err", upd_err, 0);
      check("rst_ram_b_wr", ram_b_wr, 0);
      check("rst_ram_b_addr", ram_b_addr, 0);
      check("rst_ram_b_din", ram_b_din, 0);
      check("ram_a_addr_comb", ram_a_addr, 10'h2A5);
      rst_n = 1'b1;

      load(10'd5,   node(32'h0A000000, 10'd3, 10'd7, 16'h0042, 1'b1));
      load(10'd6,   node(32'h80000000, 10'h010, 10'h020, 16'h1234, 1'b0));
      load(10'd7,   node(32'h00000100, 10'd1, 10'd2, 16'hBEEF, 1'b1));
      load(10'h3FF, node(32'h00000000, 10'h0AA, 10'h0BB, 16'hDEAD, 1'b1));
      load(10'd9,   node(32'h00000000, 10'h100, 10'h111, 16'h0101, 1'b1));

      // Single token: exact two-cycle latency.
      @(negedge clk);
      drive_tok(32'h0A000001, 10'd5, 16'h0000, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_not_1", out_valid, 0);
      @(negedge clk);
      check("lat_valid", out_valid, 1);
      check("lat_key", out_key, 32'h0A000001);
      check("lat_addr", out_addr, 10'd7);
      check("lat_res", out_res, 16'h0042);
      check("lat_hit", out_hit, 1);

      // Eight back-to-back tokens.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            check($sformatf("b2b_valid_%0d", c-2), out_valid, 1);
            check($sformatf("b2b_key_%0d", c-2), out_key, t_key[c-2]);
            check($sformatf("b2b_addr_%0d", c-2), out_addr, e_addr[c-2]);
            check($sformatf("b2b_res_%0d", c-2), out_res, e_res[c-2]);
            check($sformatf("b2b_hit_%0d", c-2), out_hit, e_hit[c-2]);
         end
         if (c < 8) drive_tok(t_key[c], t_addr[c], t_res[c], t_hit[c]);
         else       in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_drain", out_valid, 0);

      // Updates: clean write, then corrupted read-back.
      do_update(10'd9, node(32'h0, 10'h200, 10'h222, 16'h0202, 1'b1), 1'b0, 10'h111);
      corrupt = 1'b1;
      do_update(10'd9, node(32'h0, 10'h300, 10'h333, 16'h0303, 1'b1), 1'b1, 10'h222);
      corrupt = 1'b0;
      check("mem9_written", mem[9], node(32'h0, 10'h300, 10'h333, 16'h0303, 1'b1));

      // Reset during READ with a lookup in flight.
      @(negedge clk);
      upd_valid = 1'b1; upd_addr = 10'd12; upd_data = 72'h123456789ABCDEF012;
      @(negedge clk);
      upd_valid = 1'b0;
      drive_tok(32'h0A000001, 10'd5, 16'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rr_ready", upd_ready, 1);
      check("rr_done", upd_done, 0);
      check("rr_out_valid", out_valid, 0);
      check("rr_out_addr", out_addr, 10'h3FF);
      check("rr_wr", ram_b_wr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rr_no_done", upd_done, 0);
         check("rr_no_token", out_valid, 0);
      end
      do_update(10'd9, node(32'h0, 10'h200, 10'h222, 16'h0202, 1'b1), 1'b0, 10'h333);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
